// File: rtl/uart_rx.sv
// uart_rx: one-bit-per-clock UART deframer with a one-entry output holding
// register, framing-error pulse and sticky overrun flag.
//
// Ports:
//   CLK          rising-edge clock
//   ASYNCRESET   asynchronous, active-high reset
//   rx           serial line, idles high, sampled every CLK edge
//   ready        consumer accepts data when valid & ready
//   overrun_clr  clears the sticky overrun flag
//   data         received byte, held while valid
//   valid        holding register holds an unconsumed byte
//   frame_err    one-cycle pulse after a stop bit sampled low
//   overrun      sticky: a completed byte was dropped (holding register full)
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESET,
  input  logic                  rx,
  input  logic                  ready,
  input  logic                  overrun_clr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  logic                  byte_done;
  logic                  overrun_set;

  // Deframing FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (MSB_FIRST) begin
          sr_d = {sr_q[DATA_WIDTH-2:0], rx};
        end else begin
          sr_d = {rx, sr_q[DATA_WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (rx) begin
          byte_done = 1'b1;
          state_d   = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: begin
        // A low line after a framing error is a break, not a start bit.
        if (rx) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register and overrun flag
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;

    if (byte_done) begin
      if (!valid_q || ready) begin
        // Old byte (if any) is consumed on the same edge the new one lands.
        data_d  = sr_q;
        valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    // Set has priority over clear.
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (DATA_WIDTH=8,
// MSB_FIRST=1). Inputs change 1 time unit after each rising edge; outputs are
// sampled at that same point, well away from the active edge.
module tb_uart_rx;

  logic       CLK;
  logic       ASYNCRESET;
  logic       rx;
  logic       ready;
  logic       overrun_clr;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int unsigned checks;
  int unsigned errors;

  uart_rx #(
    .DATA_WIDTH(8),
    .MSB_FIRST (1'b1)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .rx         (rx),
    .ready      (ready),
    .overrun_clr(overrun_clr),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one bit for one clock edge, return just after that edge.
  task automatic send_bit(input logic b);
    rx = b;
    @(posedge CLK);
    #1;
  endtask

  // Start bit plus 8 data bits, MSB first; stop bit left to the caller.
  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i]);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rx          = 1'b1;
    ready       = 1'b0;
    overrun_clr = 1'b0;
    ASYNCRESET  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs", {valid, frame_err, overrun, data}, 32'h0);
    ASYNCRESET = 1'b0;

    // Idle line for 50 cycles
    for (int i = 0; i < 50; i++) begin
      send_bit(1'b1);
      check("idle_outputs", {valid, frame_err, overrun, data}, 32'h0);
    end

    // 0xA5 with ready=1: valid for exactly one cycle
    ready = 1'b1;
    send_data(8'hA5);
    check("a5_valid_before_stop", valid, 1'b0);
    send_bit(1'b1);
    check("a5_valid", valid, 1'b1);
    check("a5_data", data, 8'hA5);
    send_bit(1'b1);
    check("a5_valid_drop", valid, 1'b0);
    check("a5_data_kept", data, 8'hA5);

    // Back-to-back 0x3C, 0xC3 with ready=0: second byte overruns
    ready = 1'b0;
    send_data(8'h3C);
    send_bit(1'b1);
    check("3c_valid", valid, 1'b1);
    check("3c_data", data, 8'h3C);
    check("3c_overrun", overrun, 1'b0);
    send_data(8'hC3);
    check("c3_data_held", data, 8'h3C);
    send_bit(1'b1);
    check("c3_valid_held", valid, 1'b1);
    check("c3_data_kept", data, 8'h3C);
    check("c3_overrun_set", overrun, 1'b1);
    ready = 1'b1;
    send_bit(1'b1);
    ready = 1'b0;
    check("consume_valid", valid, 1'b0);
    check("consume_overrun_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    send_bit(1'b1);
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 1'b0);

    // 0x81 with bad stop bit, line held low, then 0x55
    send_data(8'h81);
    send_bit(1'b0);
    check("81_frame_err", frame_err, 1'b1);
    check("81_no_valid", valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0);
      check("break_frame_err_low", frame_err, 1'b0);
      check("break_no_valid", valid, 1'b0);
    end
    send_bit(1'b1);
    send_data(8'h55);
    send_bit(1'b1);
    check("55_valid", valid, 1'b1);
    check("55_data", data, 8'h55);
    check("55_frame_err", frame_err, 1'b0);
    ready = 1'b1;
    send_bit(1'b1);
    ready = 1'b0;
    check("55_consumed", valid, 1'b0);

    // ready rises exactly when a second byte completes
    send_data(8'h11);
    send_bit(1'b1);
    check("11_data", data, 8'h11);
    send_data(8'h22);
    check("22_pending_data", data, 8'h11);
    ready = 1'b1;
    send_bit(1'b1);
    ready = 1'b0;
    check("22_valid", valid, 1'b1);
    check("22_data", data, 8'h22);
    check("22_overrun", overrun, 1'b0);

    // Reset mid-way through 0xFF while 0x22 is still pending
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1);
    end
    #3;
    ASYNCRESET = 1'b1;
    #1;
    check("async_reset_outputs", {valid, frame_err, overrun, data}, 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("reset_held_outputs", {valid, frame_err, overrun, data}, 32'h0);
    ASYNCRESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1);
      check("aborted_no_valid", valid, 1'b0);
    end
    send_data(8'h0F);
    send_bit(1'b1);
    check("0f_valid", valid, 1'b1);
    check("0f_data", data, 8'h0F);
    check("0f_overrun", overrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the UART transmitter: it consumes the transmitter's single-bit output line, deframes start/data/stop bits and presents each received byte on a valid/ready output with a one-entry holding register. It runs in the same clock domain as the transmitter at one bit per clock, so no oversampling and no input synchronizer are required. It also reports framing errors and overruns.

## Interface
- DATA_WIDTH, 8, number of data bits per frame.
- MSB_FIRST, 1, 1 = first data bit after the start bit is bit DATA_WIDTH-1; 0 = bit 0 first.

- CLK  input  1  clock, all state updates on rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; sampled every rising CLK edge.
- ready  input  1  consumer accepts `data` when `valid & ready`.
- overrun_clr  input  1  clears the sticky `overrun` flag.
- data  output  DATA_WIDTH  received byte, held while `valid`.
- valid  output  1  holding register contains an unconsumed byte.
- frame_err  output  1  one-cycle pulse when the stop bit sampled low.
- overrun  output  1  sticky flag: a completed byte was dropped because the holding register was full.

## Operation
- One clock; reset is asynchronous and active-high; CLK and ASYNCRESET as above.
- FSM states: IDLE, DATA, STOP, BREAK. Bit counter `cnt` is clog2(DATA_WIDTH) bits wide; shift register `sr` is DATA_WIDTH bits wide.
- IDLE: if rx==0 (start bit) -> DATA, cnt=0; else stay in IDLE.
- DATA: shift rx into sr (MSB_FIRST: sr={sr[W-2:0],rx}; else sr={rx,sr[W-1:1]}); cnt+1; at cnt==DATA_WIDTH-1 -> STOP.
- STOP: rx==1 -> byte complete, go to IDLE. rx==0 -> pulse frame_err, discard byte, go to BREAK.
- BREAK: remain until rx==1, then IDLE. A low line after a framing error is never taken as a new start bit.
- Holding register on byte complete:
  - valid==0: data<=sr, valid<=1.
  - valid==1 and ready==1: data<=sr, valid stays 1; the old byte is consumed the same cycle.
  - valid==1 and ready==0: new byte dropped, old data kept, overrun<=1.
- Consume without a completing byte: valid&ready -> valid<=0; data keeps its last value.
- overrun_clr==1 clears overrun unless an overrun occurs in the same cycle; the set wins.
- data does not change while valid==1 && ready==0.

## Timing
- Reset values: state=IDLE, cnt=0, sr=0, data=0, valid=0, frame_err=0, overrun=0. Reset applies immediately and asynchronously.
- Reset mid-frame aborts the frame. After reset is released, the receiver resynchronizes on the next high-to-low transition seen in IDLE.
- Frame is 1 start + DATA_WIDTH data + 1 stop = DATA_WIDTH+2 cycles.
- Start bit is sampled at edge 0, data at edges 1..DATA_WIDTH, stop at edge DATA_WIDTH+1.
- valid and data update on the stop-bit edge, visible the following cycle. Latency from start-bit edge to valid high is DATA_WIDTH+2 edges (10 for width 8).
- frame_err is high for exactly the cycle after the bad stop-bit edge.
- Back-to-back frames: a start bit on the edge immediately after the stop edge is accepted. There is no gap cycle, so sustained throughput is one byte per DATA_WIDTH+2 cycles.
- ready is combinationally sampled only at the clock edge. There is no combinational path from rx or ready to any output.

## Test plan
- Reset then idle line (rx=1 for 50 cycles) -> valid=0, data=0x00, frame_err=0, overrun=0 throughout.
- Frame 0xA5, MSB_FIRST, with ready=1 (rx: 0,1,0,1,0,0,1,0,1,1) -> valid high for 1 cycle, data=0xA5 from the cycle after the stop edge.
- Two back-to-back frames 0x3C then 0xC3 with ready=0 -> data=0x3C and valid held; overrun=1 after the second stop bit. Then ready=1 for 1 cycle -> valid=0. Then overrun_clr=1 -> overrun=0.
- Frame 0x81 with stop bit 0 and rx held low for 5 extra cycles, then high, then frame 0x55 -> one frame_err pulse, no valid for 0x81, no false start while low; data=0x55 received correctly.
- ready=1 on the exact cycle a second byte completes (first 0x11 pending, second 0x22) -> valid stays 1, data=0x22, overrun=0.
- ASYNCRESET pulsed mid-way through the data bits of 0xFF, then a clean frame 0x0F -> no byte output for the aborted frame; 0x0F received; all outputs 0 during reset.
